// File: rtl/asyn_fifo_stream_reader_if.sv
// ---------------------------------------------------------------------------
// asyn_fifo_stream_reader_if
//   Bundles the read-side FIFO strobe/data port and the downstream
//   valid/ready stream of asyn_fifo_stream_reader.
//
//   Parameters
//     DWIDTH   data width in bits
//     RAMLAT   RAM read latency in cycles (1..3); sets the width of s_level
//
//   Signals
//     f_valid  FIFO not-empty from the controller
//     f_en     FIFO read strobe to the controller (r_en)
//     f_data   RAM read data, RAMLAT cycles after its strobe
//     flush    synchronous discard of buffered and in-flight words
//     s_valid  stream word available
//     s_ready  consumer accepts the word
//     s_data   stream word at the buffer head
//     s_level  number of words held in the prefetch buffer
//
//   Modports
//     master   the reader itself
//     slave    the FIFO controller / RAM / consumer side
// ---------------------------------------------------------------------------
interface asyn_fifo_stream_reader_if #(
  parameter int DWIDTH = 8,
  parameter int RAMLAT = 1
);
  localparam int LVLW = $clog2(RAMLAT + 3);

  logic              f_valid;
  logic              f_en;
  logic [DWIDTH-1:0] f_data;
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [DWIDTH-1:0] s_data;
  logic [LVLW-1:0]   s_level;

  modport master (
    input  f_valid, f_data, flush, s_ready,
    output f_en, s_valid, s_data, s_level
  );

  modport slave (
    output f_valid, f_data, flush, s_ready,
    input  f_en, s_valid, s_data, s_level
  );
endinterface

// File: rtl/asyn_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// asyn_fifo_stream_reader
//   Read-clock-domain unloader for the RAM-backed asynchronous FIFO.
//   Issues FIFO read strobes against a credit window of BUFD words, captures
//   the RAM data RAMLAT cycles later into a circular prefetch buffer and
//   presents the buffer head as a back-pressurable valid/ready stream at one
//   word per cycle.
//
//   Parameters
//     DWIDTH   data width in bits
//     RAMLAT   RAM read latency in cycles, 1..3
//
//   Ports
//     clk      read-domain clock
//     rst      asynchronous, active-high reset
//     bus      asyn_fifo_stream_reader_if.master:
//                f_valid/f_en/f_data toward the FIFO controller and RAM,
//                flush, s_valid/s_ready/s_data/s_level toward the consumer
// ---------------------------------------------------------------------------
module asyn_fifo_stream_reader #(
  parameter int DWIDTH = 8,
  parameter int RAMLAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  asyn_fifo_stream_reader_if.master  bus
);

  // RAMLAT+2 slots keep a strobe in flight every cycle while a word is
  // being handed over, so the stream sustains one word per cycle.
  localparam int BUFD = RAMLAT + 2;
  localparam int LVLW = $clog2(BUFD + 1);
  localparam int IDXW = $clog2(BUFD);

  localparam logic [LVLW-1:0] BUFD_L   = LVLW'(BUFD);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BUFD - 1);

  logic [LVLW-1:0]   occ_q, occ_d;
  logic [RAMLAT-1:0] pipe_q, pipe_d;
  logic [IDXW-1:0]   rd_idx_q, rd_idx_d;
  logic [IDXW-1:0]   wr_idx_q, wr_idx_d;
  logic [DWIDTH-1:0] mem_q [BUFD];

  logic [LVLW-1:0]   infl;
  logic              credit;
  logic              f_en;
  logic              arrival;
  logic              wr_en;
  logic              s_valid;
  logic              pop;

  // BUFD need not be a power of two, so indices wrap explicitly.
  function automatic logic [IDXW-1:0] idx_inc(input logic [IDXW-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [LVLW-1:0] popcnt(input logic [RAMLAT-1:0] v);
    logic [LVLW-1:0] n;
    n = '0;
    for (int i = 0; i < RAMLAT; i++) begin
      n = n + LVLW'(v[i]);
    end
    return n;
  endfunction

  // Credit window: words held plus words already strobed must stay below
  // BUFD. A pop in the current cycle is deliberately not credited; this
  // keeps f_en off the s_ready path.
  always_comb infl = popcnt(pipe_q);

  assign credit  = (occ_q + infl) < BUFD_L;
  assign f_en    = bus.f_valid & ~bus.flush & ~rst & credit;
  assign arrival = pipe_q[RAMLAT-1];
  assign wr_en   = arrival & ~bus.flush;
  assign s_valid = (occ_q != '0);
  assign pop     = s_valid & bus.s_ready & ~bus.flush;

  always_comb begin
    pipe_d   = '0;
    rd_idx_d = '0;
    wr_idx_d = '0;
    occ_d    = '0;
    if (!bus.flush) begin
      pipe_d[0] = f_en;
      for (int i = 1; i < RAMLAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      wr_idx_d = wr_en ? idx_inc(wr_idx_q) : wr_idx_q;
      rd_idx_d = pop   ? idx_inc(rd_idx_q) : rd_idx_q;
      occ_d    = occ_q + LVLW'(wr_en) - LVLW'(pop);
    end
  end

  // State stage: strobe markers, indices, occupancy and buffer storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      pipe_q   <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      for (int i = 0; i < BUFD; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      occ_q    <= occ_d;
      pipe_q   <= pipe_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      if (wr_en) begin
        mem_q[wr_idx_q] <= bus.f_data;
      end
    end
  end

  // Output stage: combinational head select from registered storage
  assign bus.f_en    = f_en;
  assign bus.s_valid = s_valid;
  assign bus.s_data  = mem_q[rd_idx_q];
  assign bus.s_level = occ_q;

  // The credit rule guarantees a free slot for every arriving word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !((occ_q == BUFD_L) && arrival && !pop));

endmodule

// File: tb/tb_asyn_fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_asyn_fifo_stream_reader
//   Three readers (RAMLAT = 1, 2, 3) share one stimulus. Each has a RAM
//   model that returns the strobed word RAMLAT cycles later and a queue
//   model (buffer queue + in-flight queue) checked every cycle, plus
//   directed literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_asyn_fifo_stream_reader;

  logic clk = 1'b0;
  logic rst, fv, fl, sr;

  logic [7:0] fdat  [1:3];
  logic [3:1] fen_w;
  logic [3:1] sv_w;
  logic [7:0] sd_w  [1:3];
  logic [2:0] lvl_w [1:3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] seed;
  int         seed_gen = 0;

  // Model state per lane
  logic [7:0] mq  [1:3][$];
  int         ift [1:3][$];
  logic [7:0] ifd [1:3][$];
  logic [7:0] src [1:3];
  logic [7:0] got [1:3][$];
  int         fenc [1:3];

  always #5 clk = ~clk;

  for (genvar g = 1; g <= 3; g++) begin : lane
    asyn_fifo_stream_reader_if #(.DWIDTH(8), .RAMLAT(g)) bus ();

    asyn_fifo_stream_reader #(.DWIDTH(8), .RAMLAT(g)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.f_valid = fv;
    assign bus.flush   = fl;
    assign bus.s_ready = sr;
    assign bus.f_data  = fdat[g];
    assign fen_w[g]    = bus.f_en;
    assign sv_w[g]     = bus.s_valid;
    assign sd_w[g]     = bus.s_data;
    assign lvl_w[g]    = 3'(bus.s_level);
  end

  task automatic check(input string nm, input int ln, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s lane=%0d t=%0t got=0x%0h want=0x%0h", nm, ln, $time, act, exp);
    end
  endtask

  // Model + per-cycle compare, one time unit before each rising edge
  initial begin : cmp
    int  last_gen;
    int  bd;
    bit  arr, efen, esv;
    last_gen = 0;
    for (int g = 1; g <= 3; g++) begin
      fdat[g] = 8'hEE;
      src[g]  = 8'h00;
      fenc[g] = 0;
    end
    forever begin
      @(negedge clk);
      #4;
      if (seed_gen != last_gen) begin
        last_gen = seed_gen;
        for (int g = 1; g <= 3; g++) src[g] = seed;
      end
      for (int g = 1; g <= 3; g++) begin
        bd = g + 2;
        if (rst) begin
          mq[g].delete();
          ift[g].delete();
          ifd[g].delete();
          fdat[g] = 8'hEE;
          check("rst_fen", g, int'(fen_w[g]), 0);
          check("rst_sv",  g, int'(sv_w[g]),  0);
          check("rst_lvl", g, int'(lvl_w[g]), 0);
          check("rst_sd",  g, int'(sd_w[g]),  0);
        end else begin
          arr     = (ift[g].size() > 0) && (ift[g][0] == cyc);
          fdat[g] = arr ? ifd[g][0] : 8'hEE;
          efen    = fv && !fl && ((mq[g].size() + ift[g].size()) < bd);
          esv     = (mq[g].size() != 0);
          check("m_fen", g, int'(fen_w[g]), int'(efen));
          check("m_sv",  g, int'(sv_w[g]),  int'(esv));
          check("m_lvl", g, int'(lvl_w[g]), mq[g].size());
          check("m_occ_bound", g, int'(int'(lvl_w[g]) <= bd), 1);
          if (esv) check("m_sd", g, int'(sd_w[g]), int'(mq[g][0]));
          if (fen_w[g]) fenc[g]++;
          if (fl) begin
            mq[g].delete();
            ift[g].delete();
            ifd[g].delete();
          end else begin
            if (esv && sr) begin
              got[g].push_back(sd_w[g]);
              void'(mq[g].pop_front());
            end
            if (arr) begin
              mq[g].push_back(ifd[g].pop_front());
              void'(ift[g].pop_front());
            end
            if (efen) begin
              ift[g].push_back(cyc + g);
              ifd[g].push_back(src[g]);
              src[g] = src[g] + 8'd1;
            end
          end
        end
      end
      cyc++;
    end
  end

  // Directed and random stimulus with literal expectations
  initial begin : stim
    int b [1:3];
    int fc0;

    rst = 1'b1; fv = 1'b0; fl = 1'b0; sr = 1'b0; seed = 8'h00;
    repeat (2) @(negedge clk);
    #2;
    for (int g = 1; g <= 3; g++) begin
      check("reset_fen", g, int'(fen_w[g]), 0);
      check("reset_sv",  g, int'(sv_w[g]),  0);
      check("reset_sd",  g, int'(sd_w[g]),  0);
      check("reset_lvl", g, int'(lvl_w[g]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fill and drain: five words 0x11..0x15, consumer always ready
    for (int g = 1; g <= 3; g++) b[g] = got[g].size();
    seed = 8'h11; seed_gen++; sr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fv = (k < 5);
      #2;
      check("fill_fen", 1, int'(fen_w[1]), int'(k < 5));
      check("fill_sv",  1, int'(sv_w[1]),  int'(k >= 2 && k <= 6));
      if (k >= 2 && k <= 6) check("fill_sd", 1, int'(sd_w[1]), 'h11 + k - 2);
      check("fill_lvl_max", 1, int'(lvl_w[1] <= 3'd2), 1);
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    for (int g = 1; g <= 3; g++) begin
      check("fill_count", g, got[g].size() - b[g], 5);
      for (int i = 0; i < 5; i++)
        if (b[g] + i < got[g].size()) check("fill_order", g, int'(got[g][b[g]+i]), 'h11 + i);
    end

    // Back-pressure then resume: ten words 0x30.. on the RAMLAT=2 lane
    for (int g = 1; g <= 3; g++) b[g] = got[g].size();
    fc0 = fenc[2];
    seed = 8'h30; seed_gen++;
    for (int k = 0; k < 22; k++) begin
      fv = (k <= 14);
      sr = (k >= 8);
      #2;
      if (k <= 7) check("bp_fen", 2, int'(fen_w[2]), int'(k <= 3));
      if (k == 8) check("bp_fen_hold", 2, int'(fen_w[2]), 0);
      if (k == 9) check("bp_fen_restart", 2, int'(fen_w[2]), 1);
      if (k == 5) check("bp_lvl3", 2, int'(lvl_w[2]), 3);
      if (k == 6 || k == 7) check("bp_lvl4", 2, int'(lvl_w[2]), 4);
      if (k >= 3 && k <= 7) begin
        check("bp_sv_hold", 2, int'(sv_w[2]), 1);
        check("bp_sd_hold", 2, int'(sd_w[2]), 'h30);
      end
      if (k >= 8 && k <= 17) check("bp_nogap", 2, int'(sv_w[2]), 1);
      if (k >= 18) check("bp_empty", 2, int'(sv_w[2]), 0);
      @(negedge clk);
    end
    check("bp_pulses", 2, fenc[2] - fc0, 10);
    check("bp_count", 2, got[2].size() - b[2], 10);
    for (int i = 0; i < 10; i++)
      if (b[2] + i < got[2].size()) check("bp_order", 2, int'(got[2][b[2]+i]), 'h30 + i);
    fv = 1'b0; sr = 1'b1;
    repeat (6) @(negedge clk);

    // Empty FIFO: a single f_valid pulse yields a single word
    for (int g = 1; g <= 3; g++) b[g] = got[g].size();
    seed = 8'h5C; seed_gen++;
    for (int k = 0; k < 12; k++) begin
      fv = (k == 0);
      sr = (k >= 8);
      #2;
      for (int g = 1; g <= 3; g++) begin
        check("empty_fen", g, int'(fen_w[g]), int'(k == 0));
        check("empty_sv",  g, int'(sv_w[g]),  int'(k >= g + 1 && k <= 8));
        if (k >= g + 1 && k <= 8) check("empty_sd", g, int'(sd_w[g]), 'h5C);
      end
      @(negedge clk);
    end
    for (int g = 1; g <= 3; g++) begin
      check("empty_count", g, got[g].size() - b[g], 1);
      if (b[g] < got[g].size()) check("empty_word", g, int'(got[g][b[g]]), 'h5C);
    end

    // Flush with two words in flight; 0xA5 is the next word out
    for (int g = 1; g <= 3; g++) b[g] = got[g].size();
    seed = 8'hA3; seed_gen++; sr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      fv = (k <= 2) || (k == 4);
      fl = (k == 2);
      #2;
      if (k == 2) for (int g = 1; g <= 3; g++) check("flush_fen_low", g, int'(fen_w[g]), 0);
      if (k == 3) for (int g = 1; g <= 3; g++) check("flush_lvl0", g, int'(lvl_w[g]), 0);
      if (k >= 3 && k <= 7) check("flush_sv_low", 3, int'(sv_w[3]), 0);
      if (k == 8) begin
        check("flush_sv_a5", 3, int'(sv_w[3]), 1);
        check("flush_sd_a5", 3, int'(sd_w[3]), 'hA5);
      end
      if (k == 9) check("flush_drained", 3, int'(sv_w[3]), 0);
      @(negedge clk);
    end
    fl = 1'b0; fv = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      check("flush_count", g, got[g].size() - b[g], 1);
      if (b[g] < got[g].size()) check("flush_first", g, int'(got[g][b[g]]), 'hA5);
    end

    // Reset while three words are held on the RAMLAT=1 lane
    seed = 8'h70; seed_gen++; sr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      fv = 1'b1;
      #2;
      if (k == 5) begin
        check("rstmid_lvl3", 1, int'(lvl_w[1]), 3);
        check("rstmid_fen_full", 1, int'(fen_w[1]), 0);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    for (int g = 1; g <= 3; g++) begin
      check("rstmid_fen", g, int'(fen_w[g]), 0);
      check("rstmid_sv",  g, int'(sv_w[g]),  0);
      check("rstmid_lvl", g, int'(lvl_w[g]), 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; fv = 1'b0;
    @(negedge clk);
    for (int g = 1; g <= 3; g++) b[g] = got[g].size();
    seed = 8'h90; seed_gen++; fv = 1'b1; sr = 1'b1;
    @(negedge clk);
    fv = 1'b0;
    repeat (8) @(negedge clk);
    for (int g = 1; g <= 3; g++) begin
      check("rstmid_count", g, got[g].size() - b[g], 1);
      if (b[g] < got[g].size()) check("rstmid_first", g, int'(got[g][b[g]]), 'h90);
    end

    // Random f_valid / s_ready with occasional flush
    seed = 8'h00; seed_gen++;
    for (int k = 0; k < 10000; k++) begin
      fv = ($urandom_range(0, 3) != 0);
      sr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    fv = 1'b0; fl = 1'b0; sr = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    for (int g = 1; g <= 3; g++) begin
      check("rand_drain_lvl", g, int'(lvl_w[g]), 0);
      check("rand_drain_sv",  g, int'(sv_w[g]),  0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
